alu_scheduler: RTL and testbench
================================

# alu_scheduler

Two-requester command scheduler for the ALU top. It arbitrates between two requesters, drives the ALU operand and function inputs, and waits a fixed latency for the registered unit outputs. It then selects the output of the unit decoded from `FUN[3:2]` and returns it on a single valid/ready response channel tagged with the requester index. It sits between the datapath masters and the ALU, and is the only driver of the ALU's `A`, `B` and `ALU_FUN` inputs.

## Interface
- `DATA_WIDTH`, 16: operand width; also the arith, logic and shift output width.
- `FUN_WIDTH`, 4: ALU function code width. Bits [3:2] select the class, bits [1:0] select the op.
- `CMP_WIDTH`, 4: compare-unit output width.
- `ALU_LAT`, 1: cycles from operands applied to ALU outputs valid. Must be at least 1.
- `CLK` in 1: clock.
- `RST` in 1: reset, synchronous, active-high.
- `REQ0_VALID`/`REQ1_VALID` in 1: command valid.
- `REQ0_READY`/`REQ1_READY` out 1: command accepted this cycle.
- `REQ0_A`/`REQ1_A`, `REQ0_B`/`REQ1_B` in DATA_WIDTH: operands.
- `REQ0_FUN`/`REQ1_FUN` in FUN_WIDTH: function code.
- `ALU_A`, `ALU_B` out DATA_WIDTH: to ALU `A`/`B`, registered.
- `ALU_FUN` out FUN_WIDTH: to ALU `ALU_FUN`, registered.
- `Arith_OUT`, `Logic_OUT`, `SHIFT_OUT` in DATA_WIDTH: unit results.
- `CMP_OUT` in CMP_WIDTH: compare result.
- `Carry_OUT` in 1: arith carry.
- `Arith_Flag`, `Logic_Flag`, `CMP_Flag`, `SHIFT_Flag` in 1: unit output-valid flags.
- `RSP_VALID` out 1: response valid.
- `RSP_READY` in 1: response accepted.
- `RSP_DEST` out 1: index of the requester that issued the command.
- `RSP_DATA` out DATA_WIDTH: selected result. The compare result is zero-extended.
- `RSP_CARRY` out 1: `Carry_OUT` for class 00, else 0.
- `RSP_ERR` out 1: the selected unit's flag was low at capture.
- `BUSY` out 1: the scheduler is not in IDLE.

## Operation
- FSM states are IDLE, ISSUE, WAIT, RESP.
  - **IDLE:** `REQx_READY` = IDLE & `REQx_VALID` & grant_x. This is combinational from the state, the valids and the pointer. On a handshake, the scheduler latches A, B, FUN and the requester index into the ALU registers and the tag register, then goes to ISSUE.
  - **ISSUE:** one cycle; the operands are applied to the ALU. Goes to WAIT with the counter loaded to `ALU_LAT`−1.
  - **WAIT:** when the counter is 0, the scheduler captures the selected result into the RSP registers and goes to RESP. Otherwise it decrements the counter.
  - **RESP:** `RSP_VALID`=1. On `RSP_READY` it goes to IDLE.
- Result select by `FUN[3:2]`:
  - 00: `Arith_OUT`, `Carry_OUT`, `Arith_Flag`.
  - 01: `Logic_OUT`, `Logic_Flag`.
  - 10: `{0, CMP_OUT}`, `CMP_Flag`.
  - 11: `SHIFT_OUT`, `SHIFT_Flag`.
- `ALU_A`, `ALU_B` and `ALU_FUN` hold their values from acceptance until the next acceptance.
- Simultaneous valids: only one command is granted per cycle, selected by the arbitration policy (see Configuration).
- A request held valid while the scheduler is BUSY is not accepted. The requester must hold its payload stable until READY.
- In RESP with `RSP_READY`=0, all `RSP_*` outputs are held stable.
- `RST` asserted in any state returns the FSM to IDLE on that edge. Any in-flight command is dropped with no response.
- Reset values:
  - State IDLE, pointer at requester 0, counter 0.
  - `ALU_A`, `ALU_B` = 0 and `ALU_FUN` = 0.
  - `RSP_VALID`, `RSP_DEST`, `RSP_DATA`, `RSP_CARRY`, `RSP_ERR` = 0.
  - `BUSY` = 0 and `REQx_READY` = 0.

## Timing
- Handshake at edge t: the ALU sees the operands during cycle t+1 (ISSUE).
- Capture happens at edge t+1+`ALU_LAT`, and `RSP_VALID` rises at t+2+`ALU_LAT`.
- With `ALU_LAT`=1, a request accepted at edge t produces `RSP_VALID` at t+3.
- If the response handshake occurs at edge r, the next accept can happen at edge r+1 at the earliest.
- Peak throughput is one op per `ALU_LAT`+3 cycles.
- `BUSY` and `REQx_READY` low are visible from the cycle after acceptance.

## Configuration
- `ALU_SCHED_RR_EN` defined: round-robin arbitration. The pointer moves to the other requester after each grant. On simultaneous valids, the requester at the pointer wins.
- `ALU_SCHED_RR_EN` undefined: fixed priority, requester 0 always wins. The pointer register is not built.

## Structure
- A shared package `alu_sched_pkg` holds:
  - the state enum;
  - class localparams `CLS_ARITH`=2'b00, `CLS_LOGIC`=2'b01, `CLS_CMP`=2'b10, `CLS_SHIFT`=2'b11.
- One sub-module, `alu_sched_arb`, is the 2-way arbiter. It contains the pointer register and the `ALU_SCHED_RR_EN` logic.
- The FSM, counter and result mux live in `alu_scheduler`.

## Test plan
- Req0: A=0x0005, B=0x0003, FUN=4'b0000 (add), ALU model returns 0x0008 with Arith_Flag=1, RSP_READY held 1 → RSP_VALID at t+3 with RSP_DATA=0x0008, RSP_DEST=0, RSP_ERR=0.
- Both valids in the same cycle, repeated for 4 ops, RR enabled → RSP_DEST sequence is 0,1,0,1. With the macro undefined and req0 always valid → all responses have RSP_DEST=0.
- CMP op FUN=4'b1001 with CMP_OUT=4'b0011 → RSP_DATA=0x0003 and RSP_CARRY=0.
- RSP_READY held low for 5 cycles → RSP_* stable and REQx_READY=0 throughout. Accept occurs at the edge after the response handshake.
- Selected unit flag low at capture (e.g. SHIFT_Flag=0 for FUN=4'b1100) → RSP_ERR=1.
- RST asserted during WAIT → the next cycle shows IDLE, RSP_VALID=0, ALU_FUN=0 and BUSY=0, and no response is ever issued for the dropped op.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU command scheduler.
//   state_e    : scheduler FSM states
//   CLS_*      : result class decoded from ALU_FUN[3:2]
package alu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] CLS_ARITH = 2'b00;
  localparam logic [1:0] CLS_LOGIC = 2'b01;
  localparam logic [1:0] CLS_CMP   = 2'b10;
  localparam logic [1:0] CLS_SHIFT = 2'b11;

endpackage

// File: rtl/alu_sched_arb.sv
// Two-way request arbiter for the ALU scheduler.
// Macro ALU_SCHED_RR_EN: defined -> round-robin with a pointer register,
// undefined -> fixed priority (requester 0 wins), no pointer built.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : grants allowed this cycle
//   valid0, valid1  : request valids
//   grant0, grant1  : one-hot grant (combinational)
module alu_sched_arb (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

`ifdef ALU_SCHED_RR_EN
  // Pointer names the requester that wins a tie.
  logic ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (grant0) begin
      ptr <= 1'b1;
    end else if (grant1) begin
      ptr <= 1'b0;
    end
  end

  always_comb begin
    grant0 = en & valid0 & (~valid1 | ~ptr);
    grant1 = en & valid1 & (~valid0 | ptr);
  end
`else
  // Clock and reset have no consumer in the fixed-priority build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    grant0 = en & valid0;
    grant1 = en & valid1 & ~valid0;
  end
`endif

endmodule

// File: rtl/alu_scheduler.sv
// Two-requester command scheduler in front of the ALU: arbitrates, drives
// the ALU operand/function registers, waits ALU_LAT cycles, then returns the
// result of the unit selected by FUN[3:2] on a valid/ready response channel.
// Arbitration policy set by macro ALU_SCHED_RR_EN (see alu_sched_arb).
// Ports:
//   CLK, RST                    : clock, synchronous active-high reset
//   REQx_VALID/READY/A/B/FUN    : command channels (READY combinational)
//   ALU_A, ALU_B, ALU_FUN       : registered ALU inputs
//   Arith/Logic/SHIFT_OUT, CMP_OUT, Carry_OUT, *_Flag : ALU unit results
//   RSP_VALID/READY/DEST/DATA/CARRY/ERR : response channel
//   BUSY                        : scheduler not idle
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FUN_WIDTH  = 4,
  parameter int unsigned CMP_WIDTH  = 4,
  parameter int unsigned ALU_LAT    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic [DATA_WIDTH-1:0] REQ0_A,
  input  logic [DATA_WIDTH-1:0] REQ0_B,
  input  logic [FUN_WIDTH-1:0]  REQ0_FUN,
  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  input  logic [DATA_WIDTH-1:0] REQ1_A,
  input  logic [DATA_WIDTH-1:0] REQ1_B,
  input  logic [FUN_WIDTH-1:0]  REQ1_FUN,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  input  logic [DATA_WIDTH-1:0] Arith_OUT,
  input  logic [DATA_WIDTH-1:0] Logic_OUT,
  input  logic [DATA_WIDTH-1:0] SHIFT_OUT,
  input  logic [CMP_WIDTH-1:0]  CMP_OUT,
  input  logic                  Carry_OUT,
  input  logic                  Arith_Flag,
  input  logic                  Logic_Flag,
  input  logic                  CMP_Flag,
  input  logic                  SHIFT_Flag,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic                  RSP_DEST,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  RSP_CARRY,
  output logic                  RSP_ERR,
  output logic                  BUSY
);

  localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_e                  state;
  state_e                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    tag;
  logic                    arb_en;
  logic                    grant0;
  logic                    grant1;
  logic                    accept;
  logic                    capture;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_carry;
  logic                    sel_flag;

  // Grants only in IDLE, and never while reset is asserted.
  assign arb_en = (state == ST_IDLE) & ~RST;

  alu_sched_arb u_arb (
    .clk    (CLK),
    .rst    (RST),
    .en     (arb_en),
    .valid0 (REQ0_VALID),
    .valid1 (REQ1_VALID),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)         state_nxt = ST_ISSUE;
      ST_ISSUE:                     state_nxt = ST_WAIT;
      ST_WAIT:  if (cnt == '0)      state_nxt = ST_RESP;
      ST_RESP:  if (RSP_READY)      state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: request handshakes and result capture strobe.
  always_comb begin
    REQ0_READY = grant0;
    REQ1_READY = grant1;
    accept     = grant0 | grant1;
    capture    = (state == ST_WAIT) && (cnt == '0);
  end

  // Result select by function class; compare result is zero-extended.
  always_comb begin
    sel_data  = '0;
    sel_carry = 1'b0;
    sel_flag  = 1'b0;
    case (ALU_FUN[3:2])
      CLS_ARITH: begin
        sel_data  = Arith_OUT;
        sel_carry = Carry_OUT;
        sel_flag  = Arith_Flag;
      end
      CLS_LOGIC: begin
        sel_data = Logic_OUT;
        sel_flag = Logic_Flag;
      end
      CLS_CMP: begin
        sel_data = DATA_WIDTH'(CMP_OUT);
        sel_flag = CMP_Flag;
      end
      CLS_SHIFT: begin
        sel_data = SHIFT_OUT;
        sel_flag = SHIFT_Flag;
      end
      default: ;
    endcase
  end

  // Command side: ALU operand registers, tag, latency counter, busy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ALU_A   <= '0;
      ALU_B   <= '0;
      ALU_FUN <= '0;
      tag     <= 1'b0;
      cnt     <= '0;
      BUSY    <= 1'b0;
    end else begin
      BUSY <= (state_nxt != ST_IDLE);
      if (accept) begin
        ALU_A   <= grant1 ? REQ1_A   : REQ0_A;
        ALU_B   <= grant1 ? REQ1_B   : REQ0_B;
        ALU_FUN <= grant1 ? REQ1_FUN : REQ0_FUN;
        tag     <= grant1;
      end
      if (state == ST_ISSUE) begin
        cnt <= CNT_W'(ALU_LAT - 1);
      end else if ((state == ST_WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Response side: fields load on capture and hold until the next capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RSP_VALID <= 1'b0;
      RSP_DEST  <= 1'b0;
      RSP_DATA  <= '0;
      RSP_CARRY <= 1'b0;
      RSP_ERR   <= 1'b0;
    end else if (capture) begin
      RSP_VALID <= 1'b1;
      RSP_DEST  <= tag;
      RSP_DATA  <= sel_data;
      RSP_CARRY <= sel_carry;
      RSP_ERR   <= ~sel_flag;
    end else if ((state == ST_RESP) && RSP_READY) begin
      RSP_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: ALU stub, behavioural model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_alu_scheduler;

  localparam int unsigned DW  = 16;
  localparam int unsigned FW  = 4;
  localparam int unsigned CW  = 4;
  localparam int unsigned LAT = 1;
`ifdef ALU_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [FW-1:0] req0_fun = '0, req1_fun = '0;
  logic [DW-1:0] alu_a, alu_b;
  logic [FW-1:0] alu_fun;
  logic [DW-1:0] arith_out, logic_out, shift_out;
  logic [CW-1:0] cmp_out;
  logic          carry_out, arith_flag, logic_flag, cmp_flag, shift_flag;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_dest, rsp_carry, rsp_err, busy;
  logic [DW-1:0] rsp_data;

  always #5 clk = ~clk;

  alu_scheduler #(.DATA_WIDTH(DW), .FUN_WIDTH(FW), .CMP_WIDTH(CW), .ALU_LAT(LAT)) dut (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(req0_valid), .REQ0_READY(req0_ready), .REQ0_A(req0_a), .REQ0_B(req0_b), .REQ0_FUN(req0_fun),
    .REQ1_VALID(req1_valid), .REQ1_READY(req1_ready), .REQ1_A(req1_a), .REQ1_B(req1_b), .REQ1_FUN(req1_fun),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FUN(alu_fun),
    .Arith_OUT(arith_out), .Logic_OUT(logic_out), .SHIFT_OUT(shift_out), .CMP_OUT(cmp_out),
    .Carry_OUT(carry_out), .Arith_Flag(arith_flag), .Logic_Flag(logic_flag),
    .CMP_Flag(cmp_flag), .SHIFT_Flag(shift_flag),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DEST(rsp_dest), .RSP_DATA(rsp_data),
    .RSP_CARRY(rsp_carry), .RSP_ERR(rsp_err), .BUSY(busy)
  );

  // ALU unit results; each unit's flag drops when a distinct high bit of A is set.
  typedef struct packed {
    logic [15:0] ar;
    logic        c;
    logic [15:0] lo;
    logic [3:0]  cm;
    logic [15:0] sh;
    logic [3:0]  fl;
  } alu_t;

  typedef struct packed {
    logic [15:0] data;
    logic        carry;
    logic        err;
  } rsp_t;

  function automatic alu_t calc(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    alu_t r;
    logic [16:0] s;
    case (f[1:0])
      2'd0:    s = {1'b0, a} + {1'b0, b};
      2'd1:    s = {1'b0, a} - {1'b0, b};
      2'd2:    s = {1'b0, a & b};
      default: s = {1'b0, a | b};
    endcase
    r.ar = s[15:0];
    r.c  = s[16];
    r.lo = f[0] ? (a ^ b) : ~(a & b);
    r.cm = {a > b, a < b, a == b, f[0]};
    r.sh = a << f[1:0];
    r.fl = {~a[15], ~a[14], ~a[13], ~a[12]};
    return r;
  endfunction

  // Response a command must produce, straight from the class-select rules.
  function automatic rsp_t expect_rsp(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    alu_t u;
    rsp_t r;
    u = calc(a, b, f);
    case (f[3:2])
      2'b00:   r = '{data: u.ar,           carry: u.c,  err: ~u.fl[3]};
      2'b01:   r = '{data: u.lo,           carry: 1'b0, err: ~u.fl[2]};
      2'b10:   r = '{data: {12'h000, u.cm}, carry: 1'b0, err: ~u.fl[1]};
      default: r = '{data: u.sh,           carry: 1'b0, err: ~u.fl[0]};
    endcase
    return r;
  endfunction

  // One-cycle ALU stub fed by the scheduler's registered ALU inputs.
  alu_t stub = '0;
  always @(posedge clk) stub <= calc(alu_a, alu_b, alu_fun);
  assign arith_out  = stub.ar;
  assign carry_out  = stub.c;
  assign logic_out  = stub.lo;
  assign cmp_out    = stub.cm;
  assign shift_out  = stub.sh;
  assign arith_flag = stub.fl[3];
  assign logic_flag = stub.fl[2];
  assign cmp_flag   = stub.fl[1];
  assign shift_flag = stub.fl[0];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: edges left until the response appears, response held, pointer.
  int          m_left = 0;
  bit          m_resp = 0;
  bit          m_ptr  = 0;
  logic [15:0] m_a = '0, m_b = '0;
  logic [3:0]  m_fun = '0;
  rsp_t        m_pend = '0, m_out = '0;
  bit          m_tag = 0, m_dest = 0;

  always @(negedge clk) begin : cmp_proc
    bit m_busy, w0, w1, e0, e1;
    m_busy = (m_left > 0) || m_resp;
    w0 = req0_valid && (!req1_valid || !(RR && m_ptr));
    w1 = req1_valid && (!req0_valid || (RR && m_ptr));
    e0 = !rst && !m_busy && w0;
    e1 = !rst && !m_busy && w1;
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    chk("busy",       32'(busy),       32'(m_busy));
    chk("rsp_valid",  32'(rsp_valid),  32'(m_resp));
    chk("rsp_dest",   32'(rsp_dest),   32'(m_dest));
    chk("rsp_data",   32'(rsp_data),   32'(m_out.data));
    chk("rsp_carry",  32'(rsp_carry),  32'(m_out.carry));
    chk("rsp_err",    32'(rsp_err),    32'(m_out.err));
    chk("alu_a",      32'(alu_a),      32'(m_a));
    chk("alu_b",      32'(alu_b),      32'(m_b));
    chk("alu_fun",    32'(alu_fun),    32'(m_fun));
    // Advance the model across the coming edge.
    if (rst) begin
      m_left = 0; m_resp = 0; m_ptr = 0; m_a = '0; m_b = '0; m_fun = '0;
      m_out = '0; m_dest = 0; m_tag = 0; m_pend = '0;
    end else if (!m_busy) begin
      if (e0 || e1) begin
        m_a    = e1 ? req1_a : req0_a;
        m_b    = e1 ? req1_b : req0_b;
        m_fun  = e1 ? req1_fun : req0_fun;
        m_tag  = e1;
        m_pend = expect_rsp(m_a, m_b, m_fun);
        m_left = int'(LAT) + 1;
        if (RR) m_ptr = e0;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_resp = 1;
        m_out  = m_pend;
        m_dest = m_tag;
      end
    end else if (m_resp && rsp_ready) begin
      m_resp = 0;
    end
  end

  // Present a command and hold it until accepted; t is the accepting edge.
  task automatic send(input bit idx, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] f, output int t);
    bit got;
    got = 0;
    t   = 0;
    if (!idx) begin req0_a = a; req0_b = b; req0_fun = f; req0_valid = 1; end
    else      begin req1_a = a; req1_b = b; req1_fun = f; req1_valid = 1; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((!idx && req0_ready) || (idx && req1_ready)) begin
        got = 1;
        t   = cyc + 1;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_timeout: requester %0d not accepted within 40 cycles", idx);
    end
    @(posedge clk); #2;
    if (!idx) req0_valid = 0; else req1_valid = 0;
  endtask

  // Wait for RSP_VALID; e is the first edge that samples it high.
  task automatic get_rsp(output int e, output rsp_t r, output logic d);
    bit got;
    got = 0;
    e = 0; r = '0; d = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        e   = cyc + 1;
        r   = '{data: rsp_data, carry: rsp_carry, err: rsp_err};
        d   = rsp_dest;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: no response within 40 cycles");
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1;
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int   t, e, n, stall_hi;
    rsp_t r;
    logic d;
    bit   h0, h1, g0, g1;
    logic dests [4];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",      32'(busy),      32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_alu_fun",   32'(alu_fun),   32'd0);
    chk("reset_rsp_data",  32'(rsp_data),  32'd0);

    // Single add from requester 0.
    @(posedge clk); #2;
    rst = 0;
    rsp_ready = 1;
    send(0, 16'h0005, 16'h0003, 4'b0000, t);
    get_rsp(e, r, d);
    chk("add_latency", 32'(e - t), 32'd3);
    chk("add_data",    32'(r.data), 32'h0008);
    chk("add_dest",    32'(d),      32'd0);
    chk("add_err",     32'(r.err),  32'd0);
    chk("add_carry",   32'(r.carry), 32'd0);
    @(posedge clk); #2;

    // Both requesters valid for four operations.
    do_reset();
    req0_a = 16'h0101; req0_b = 16'h0022; req0_fun = 4'b0100; req0_valid = 1;
    req1_a = 16'h0a0a; req1_b = 16'h0303; req1_fun = 4'b0001; req1_valid = 1;
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      g0 = req0_ready;
      g1 = req1_ready;
      if (rsp_valid && rsp_ready) begin
        dests[n] = rsp_dest;
        n++;
      end
      @(posedge clk); #2;
      if (g0) begin req0_a = 16'($urandom); req0_b = 16'($urandom); req0_fun = 4'($urandom); end
      if (g1) begin req1_a = 16'($urandom); req1_b = 16'($urandom); req1_fun = 4'($urandom); end
    end
    req0_valid = 0;
    req1_valid = 0;
    chk("arb_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("arb_dest%0d", i), 32'(dests[i]), RR ? 32'(i % 2) : 32'd0);

    // Compare op from requester 1: zero-extended result, no carry.
    do_reset();
    send(1, 16'h0007, 16'h0007, 4'b1001, t);
    get_rsp(e, r, d);
    chk("cmp_data",  32'(r.data),  32'h0003);
    chk("cmp_carry", 32'(r.carry), 32'd0);
    chk("cmp_dest",  32'(d),       32'd1);
    chk("cmp_err",   32'(r.err),   32'd0);
    @(posedge clk); #2;

    // Response back-pressure with requester 1 waiting.
    rsp_ready = 0;
    send(0, 16'hffff, 16'h0001, 4'b0000, t);
    req1_a = 16'h0007; req1_b = 16'h0001; req1_fun = 4'b0001; req1_valid = 1;
    get_rsp(e, r, d);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_data",   32'(rsp_data),   32'h0000);
      chk("stall_carry",  32'(rsp_carry),  32'd1);
      chk("stall_err",    32'(rsp_err),    32'd1);
      chk("stall_dest",   32'(rsp_dest),   32'd0);
      chk("stall_valid",  32'(rsp_valid),  32'd1);
      chk("stall_ready0", 32'(req0_ready), 32'd0);
      chk("stall_ready1", 32'(req1_ready), 32'd0);
    end
    @(posedge clk); #2;
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("accept_after_rsp", 32'(req1_ready), 32'd1);
    @(posedge clk); #2;
    req1_valid = 0;
    get_rsp(e, r, d);
    chk("sub_data", 32'(r.data), 32'h0006);
    chk("sub_dest", 32'(d),      32'd1);
    @(posedge clk); #2;

    // Shift op whose unit flag is low at capture.
    send(0, 16'h1000, 16'h0000, 4'b1100, t);
    get_rsp(e, r, d);
    chk("shift_err",  32'(r.err),  32'd1);
    chk("shift_data", 32'(r.data), 32'h1000);
    @(posedge clk); #2;

    // Reset while waiting on the ALU drops the command.
    send(0, 16'h0003, 16'h0004, 4'b0110, t);
    @(posedge clk); #2;
    rst = 1;
    @(posedge clk); #2;
    rst = 0;
    @(negedge clk);
    chk("drop_busy",      32'(busy),      32'd0);
    chk("drop_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("drop_alu_fun",   32'(alu_fun),   32'd0);
    stall_hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) stall_hi++;
    end
    chk("drop_no_rsp", 32'(stall_hi), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk); #2;
      rst = ($urandom_range(0, 99) == 0);
      if (h0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_a = 16'($urandom); req0_b = 16'($urandom); req0_fun = 4'($urandom);
      end
      if (h1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_a = 16'($urandom); req1_b = 16'($urandom); req1_fun = 4'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    rst = 0;
    req0_valid = 0;
    req1_valid = 0;
    rsp_ready = 1;
    repeat (10) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
